// File: rtl/board_refill.sv
// board_refill: fills the empty cells (colour 0) of an 8x8 game board with
// pseudo-random colours from a free-running 16-bit LFSR.
//
// A board snapshot is latched on start. The 64 cells are then scanned one per
// cycle in row-major order, and the refilled board is published with a
// one-cycle generated pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request a refill pass (sampled only while idle)
//   board_in   192-bit board snapshot, cell i at bits i*3 +: 3, 0 = empty
//   board_out  last refilled board, same packing, held between passes
//   busy       high while a pass is in progress
//   generated  one-cycle pulse when board_out has just been updated
//   fill_count number of cells filled in the last pass (0..64)
module board_refill #(
    parameter int          NUM_COLORS = 5,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [191:0] board_in,
    output logic [191:0] board_out,
    output logic         busy,
    output logic         generated,
    output logic [6:0]   fill_count
);

    localparam logic [2:0] NC3 = 3'(NUM_COLORS);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [191:0]   work_q, work_d;
    logic [191:0]   board_out_q, board_out_d;
    logic [5:0]     idx_q, idx_d;
    logic [6:0]     cnt_q, cnt_d;
    logic [6:0]     fill_q, fill_d;
    logic [15:0]    lfsr_q, lfsr_d;
    logic           busy_q, busy_d;
    logic           gen_q, gen_d;

    logic [7:0]     base_s;
    logic [2:0]     cell_s;
    logic [2:0]     colour_s;
    logic [191:0]   work_upd_s;
    logic [6:0]     cnt_upd_s;

    // Fibonacci step for x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Fold a 3-bit raw value into the legal colour range 1..NUM_COLORS.
    function automatic logic [2:0] map_colour(input logic [2:0] c);
        if (c < NC3) begin
            return c + 3'd1;
        end else begin
            return c - NC3 + 3'd1;
        end
    endfunction

    // Cell datapath, next-state logic and output staging.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        board_out_d = board_out_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        fill_d      = fill_q;
        busy_d      = busy_q;
        gen_d       = 1'b0;
        lfsr_d      = lfsr_step(lfsr_q);

        base_s     = {2'b00, idx_q} * 8'd3;
        cell_s     = work_q[base_s +: 3];
        colour_s   = map_colour(lfsr_q[2:0]);
        work_upd_s = work_q;
        cnt_upd_s  = cnt_q;
        if (cell_s == 3'd0) begin
            work_upd_s[base_s +: 3] = colour_s;
            cnt_upd_s               = cnt_q + 7'd1;
        end else begin
            work_upd_s = work_q;
            cnt_upd_s  = cnt_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = board_in;
                    idx_d   = 6'd0;
                    cnt_d   = 7'd0;
                    busy_d  = 1'b1;
                    state_d = SCAN;
                end else begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            SCAN: begin
                work_d = work_upd_s;
                cnt_d  = cnt_upd_s;
                // Terminate on the last index explicitly rather than on wrap,
                // so the final cell is folded into the published board.
                if (idx_q == 6'd63) begin
                    board_out_d = work_upd_s;
                    fill_d      = cnt_upd_s;
                    gen_d       = 1'b1;
                    busy_d      = 1'b0;
                    idx_d       = 6'd0;
                    state_d     = IDLE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = SCAN;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= 192'd0;
            board_out_q <= 192'd0;
            idx_q       <= 6'd0;
            cnt_q       <= 7'd0;
            fill_q      <= 7'd0;
            lfsr_q      <= SEED;
            busy_q      <= 1'b0;
            gen_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            board_out_q <= board_out_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            fill_q      <= fill_d;
            lfsr_q      <= lfsr_d;
            busy_q      <= busy_d;
            gen_q       <= gen_d;
        end
    end

    assign board_out  = board_out_q;
    assign busy       = busy_q;
    assign generated  = gen_q;
    assign fill_count = fill_q;

endmodule

// File: tb/tb_board_refill.sv
// Testbench for board_refill.
//
// A reference process runs at each rising edge. It tracks the LFSR and the
// pass timing, and pushes the predicted refilled board onto a queue whenever
// a start is accepted. A monitor on the falling edge compares busy,
// generated, fill_count, board_out and the LFSR against that model. It also
// consumes one queue entry per generated pulse.
module tb_board_refill;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [191:0] board_in;
    logic [191:0] board_out;
    logic         busy;
    logic         generated;
    logic [6:0]   fill_count;

    board_refill #(.NUM_COLORS(5), .SEED(16'hACE1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .board_in   (board_in),
        .board_out  (board_out),
        .busy       (busy),
        .generated  (generated),
        .fill_count (fill_count)
    );

    typedef struct {
        logic [191:0] b;
        logic [6:0]   f;
    } exp_t;

    exp_t        q[$];
    int          rd_ptr = 0;
    int          n_checks = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    logic [15:0] m_lfsr;
    logic        m_active = 1'b0;
    int          m_cnt = 0;
    logic        m_busy = 1'b0;
    logic        m_gen = 1'b0;
    logic        m_flush = 1'b0;
    logic        mon_en = 1'b0;
    logic        hold_phase = 1'b0;
    logic        done = 1'b0;
    logic [191:0] held_b = 192'd0;
    logic [6:0]   held_f = 7'd0;
    int          last_gen_cyc = 0;
    logic        last_gen_hold = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [2:0] colour(input logic [2:0] c);
        if (c < 3'd5) return c + 3'd1;
        else return c - 3'd4;
    endfunction

    // Cell i is processed with the LFSR value i+1 steps after the start edge.
    function automatic exp_t predict(input logic [191:0] b, input logic [15:0] l0);
        exp_t        e;
        logic [15:0] l;
        l   = l0;
        e.b = b;
        e.f = 7'd0;
        for (int i = 0; i < 64; i++) begin
            l = step(l);
            if (e.b[i*3 +: 3] == 3'd0) begin
                e.b[i*3 +: 3] = colour(l[2:0]);
                e.f = e.f + 7'd1;
            end
        end
        return e;
    endfunction

    function automatic logic [191:0] const_board(input logic [2:0] v);
        logic [191:0] b;
        for (int i = 0; i < 64; i++) b[i*3 +: 3] = v;
        return b;
    endfunction

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    // Reference model of pass timing and LFSR, sampled at the active edge.
    always @(posedge clk) begin
        cyc_cnt++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_busy   = 1'b0;
            m_gen    = 1'b0;
            m_lfsr   = 16'hACE1;
            m_flush  = 1'b1;
        end else begin
            m_flush = 1'b0;
            m_gen   = 1'b0;
            if (m_active) begin
                m_cnt++;
                if (m_cnt == 64) begin
                    m_active = 1'b0;
                    m_gen    = 1'b1;
                end
            end else if (start) begin
                q.push_back(predict(board_in, m_lfsr));
                m_active = 1'b1;
                m_cnt    = 0;
            end
            m_busy = m_active;
            m_lfsr = step(m_lfsr);
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (m_flush) begin
                rd_ptr        = q.size();
                held_b        = 192'd0;
                held_f        = 7'd0;
                last_gen_hold = 1'b0;
                chk("lfsr_after_reset", {176'd0, dut.lfsr_q}, {176'd0, 16'hACE1});
            end
            chk("busy", {191'd0, busy}, {191'd0, m_busy});
            chk("generated", {191'd0, generated}, {191'd0, m_gen});
            chk("lfsr", {176'd0, dut.lfsr_q}, {176'd0, m_lfsr});
            if (generated) begin
                if (rd_ptr >= q.size()) begin
                    chk("gen_unexpected", 192'd1, 192'd0);
                end else begin
                    chk("board_out", board_out, q[rd_ptr].b);
                    chk("fill_count", {185'd0, fill_count}, {185'd0, q[rd_ptr].f});
                    held_b = q[rd_ptr].b;
                    held_f = q[rd_ptr].f;
                    rd_ptr++;
                end
                begin
                    logic ok;
                    ok = 1'b1;
                    for (int i = 0; i < 64; i++)
                        if (board_out[i*3 +: 3] < 3'd1 || board_out[i*3 +: 3] > 3'd5) ok = 1'b0;
                    chk("cell_range", {191'd0, ok}, 192'd1);
                end
                if (hold_phase && last_gen_hold)
                    chk("gen_interval", 192'(cyc_cnt - last_gen_cyc), 192'd65);
                last_gen_cyc  = cyc_cnt;
                last_gen_hold = hold_phase;
            end else begin
                chk("board_out_hold", board_out, held_b);
                chk("fill_count_hold", {185'd0, fill_count}, {185'd0, held_f});
            end
            if (done) begin
                chk("all_passes_seen", 192'(rd_ptr), 192'(q.size()));
                mon_en = 1'b0;
            end
        end
    end

    task automatic pass_pulse(input logic [191:0] b);
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (70) @(negedge clk);
    endtask

    initial begin
        logic [191:0] b;
        rst_n    = 1'b0;
        start    = 1'b0;
        board_in = 192'd0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Fully empty board: all 64 cells filled.
        pass_pulse(192'd0);

        // Full board: unchanged, fill_count 0.
        pass_pulse(const_board(3'd2));

        // Holes at cells 4 and 12 only.
        b = const_board(3'd1);
        b[4*3 +: 3]  = 3'd0;
        b[12*3 +: 3] = 3'd0;
        pass_pulse(b);

        // start re-asserted at k+10 and board_in toggled during the scan.
        b = 192'd0;
        for (int i = 0; i < 64; i += 2) b[(i+1)*3 +: 3] = 3'd3;
        board_in = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            board_in = ~board_in;
            @(negedge clk);
        end
        board_in = const_board(3'd4);
        repeat (50) @(negedge clk);

        // start held high: back-to-back passes.
        board_in   = 192'd0;
        hold_phase = 1'b1;
        start      = 1'b1;
        repeat (3*65 + 10) @(negedge clk);
        start = 1'b0;
        repeat (70) @(negedge clk);
        hold_phase = 1'b0;

        // Reset at edge k+30 of a pass, then a clean pass.
        board_in = 192'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        pass_pulse(const_board(3'd5) ^ {189'd0, 3'd5});

        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
